// File: rtl/gyro_frame_deserializer.sv
// Gyro high-speed link receiver: recovers 48-bit words from the DTX/DSYNC
// pair, buffers them in a small FIFO behind an AXI-stream master and keeps
// saturating frame/error statistics.
module gyro_frame_deserializer #(
  parameter int DPWR  = 2,
  parameter int CNT_W = 16
) (
  input  logic             txclk,
  input  logic             tx_rstn,
  input  logic             enable,
  input  logic             stat_clear,
  input  logic             dtx,
  input  logic             dsync,
  output logic [47:0]      m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [DPWR:0]    fill,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] short_err_cnt,
  output logic [CNT_W-1:0] long_err_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  typedef enum logic [1:0] {HUNT, ARMED, RECV} state_t;

  localparam int            DEPTH    = 1 << DPWR;
  localparam logic [DPWR:0] FULL_LVL = {1'b1, {DPWR{1'b0}}};
  localparam logic [5:0]    LAST_BIT = 6'd47;

  state_t      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [46:0] sr_q, sr_d;

  logic        frame_done;
  logic        short_err;
  logic        long_err;
  logic [47:0] word;

  logic [47:0]   mem_q [DEPTH];
  logic [DPWR:0] wr_ptr_q, rd_ptr_q;
  logic          fifo_empty, fifo_full;
  logic          pop, push_ok, push_drop;

  logic [CNT_W-1:0] frame_cnt_q, short_err_cnt_q, long_err_cnt_q, ovf_cnt_q;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Receiver state, bit counter and shift register.
  always_ff @(posedge txclk or negedge tx_rstn) begin
    if (!tx_rstn) begin
      state_q   <= HUNT;
      bit_cnt_q <= '0;
      sr_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
    end
  end

  // Next-state logic: hunt for a delimiter, then shift in bits until the next one.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    if (!enable) begin
      state_d   = HUNT;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        HUNT: begin
          if (dsync) state_d = ARMED;
        end
        ARMED: begin
          if (!dsync) begin
            state_d   = RECV;
            sr_d      = {sr_q[45:0], dtx};
            bit_cnt_d = 6'd1;
          end
        end
        RECV: begin
          if (!dsync) begin
            if (bit_cnt_q < LAST_BIT) begin
              sr_d      = {sr_q[45:0], dtx};
              bit_cnt_d = bit_cnt_q + 6'd1;
            end else begin
              state_d   = HUNT;
              bit_cnt_d = '0;
            end
          end else begin
            state_d   = ARMED;
            bit_cnt_d = '0;
          end
        end
        default: begin
          state_d   = HUNT;
          bit_cnt_d = '0;
        end
      endcase
    end
  end

  // Frame outcome strobes: a delimiter or an over-long run while receiving.
  always_comb begin
    frame_done = 1'b0;
    short_err  = 1'b0;
    long_err   = 1'b0;
    word       = {sr_q, dtx};
    if (enable && state_q == RECV) begin
      if (dsync) begin
        if (bit_cnt_q == LAST_BIT) frame_done = 1'b1;
        else                       short_err  = 1'b1;
      end else if (bit_cnt_q == LAST_BIT) begin
        long_err = 1'b1;
      end
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (fill == FULL_LVL);
  assign pop        = !fifo_empty && m_tready;
  assign push_ok    = frame_done && (!fifo_full || pop);
  assign push_drop  = frame_done && fifo_full && !pop;

  // FIFO pointers; a push into a full FIFO is only taken when a pop frees a slot.
  always_ff @(posedge txclk or negedge tx_rstn) begin
    if (!tx_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage; contents are only visible through the valid-gated head.
  always_ff @(posedge txclk) begin
    if (push_ok) mem_q[wr_ptr_q[DPWR-1:0]] <= word;
  end

  assign fill     = wr_ptr_q - rd_ptr_q;
  assign m_tvalid = !fifo_empty;
  assign m_tdata  = m_tvalid ? mem_q[rd_ptr_q[DPWR-1:0]] : 48'h0;

  // Saturating statistics; a clear beats any same-cycle increment.
  always_ff @(posedge txclk or negedge tx_rstn) begin
    if (!tx_rstn) begin
      frame_cnt_q     <= '0;
      short_err_cnt_q <= '0;
      long_err_cnt_q  <= '0;
      ovf_cnt_q       <= '0;
    end else if (stat_clear) begin
      frame_cnt_q     <= '0;
      short_err_cnt_q <= '0;
      long_err_cnt_q  <= '0;
      ovf_cnt_q       <= '0;
    end else begin
      if (push_ok)   frame_cnt_q     <= satInc(frame_cnt_q);
      if (short_err) short_err_cnt_q <= satInc(short_err_cnt_q);
      if (long_err)  long_err_cnt_q  <= satInc(long_err_cnt_q);
      if (push_drop) ovf_cnt_q       <= satInc(ovf_cnt_q);
    end
  end

  assign frame_cnt     = frame_cnt_q;
  assign short_err_cnt = short_err_cnt_q;
  assign long_err_cnt  = long_err_cnt_q;
  assign ovf_cnt       = ovf_cnt_q;

endmodule

// File: tb/tb_gyro_frame_deserializer.sv
// Scoreboard bench for gyro_frame_deserializer: stimulus queues expected
// words, a negedge monitor pops and compares each accepted output word.
module tb_gyro_frame_deserializer;

  logic        txclk = 1'b0;
  logic        tx_rstn;
  logic        enable;
  logic        stat_clear;
  logic        dtx;
  logic        dsync;
  logic [47:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [2:0]  fill;
  logic [15:0] frame_cnt, short_err_cnt, long_err_cnt, ovf_cnt;

  logic [47:0] expQ [$];
  logic [47:0] expHead;
  int          checks = 0;
  int          passes = 0;

  logic [47:0] t5w [6] = '{48'h1111_2222_3333, 48'h4444_5555_6666, 48'h7777_8888_9999,
                           48'hAAAA_BBBB_CCCC, 48'hDDDD_EEEE_FFFF, 48'h0123_4567_89AB};
  logic [47:0] w;

  gyro_frame_deserializer #(.DPWR(2), .CNT_W(16)) dut (
    .txclk(txclk), .tx_rstn(tx_rstn), .enable(enable), .stat_clear(stat_clear),
    .dtx(dtx), .dsync(dsync), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .fill(fill), .frame_cnt(frame_cnt),
    .short_err_cnt(short_err_cnt), .long_err_cnt(long_err_cnt), .ovf_cnt(ovf_cnt)
  );

  // Free-running link bit clock.
  always #5 txclk = ~txclk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Drive one link cycle, let it be sampled, then step clear of the edge.
  task automatic applyStimulus(input logic ds, input logic d);
    dsync = ds;
    dtx   = d;
    @(posedge txclk);
    #1;
  endtask

  task automatic sendFrame(input logic [47:0] fw, input bit expectPush);
    if (expectPush) expQ.push_back(fw);
    for (int i = 47; i >= 1; i--) applyStimulus(1'b0, fw[i]);
    applyStimulus(1'b1, fw[0]);
  endtask

  task automatic clearStats();
    stat_clear = 1'b1;
    applyStimulus(1'b1, 1'b0);
    stat_clear = 1'b0;
    checkOutput("clear_frame_cnt", 64'(frame_cnt), 64'd0);
    checkOutput("clear_err_cnts", 64'({short_err_cnt, long_err_cnt, ovf_cnt}), 64'd0);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40 && expQ.size() != 0; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("drain_pending", 64'(expQ.size()), 64'd0);
  endtask

  // Monitor: every word the DUT hands over must be the oldest expected one.
  always @(negedge txclk) begin
    if (tx_rstn && m_tvalid && m_tready) begin
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_word: actual=%0h required=none", m_tdata);
      end else begin
        expHead = expQ.pop_front();
        checkOutput("word", 64'(m_tdata), 64'(expHead));
      end
    end
  end

  initial begin
    tx_rstn = 1'b0; enable = 1'b1; stat_clear = 1'b0;
    dsync = 1'b1; dtx = 1'b0; m_tready = 1'b1;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("reset_valid", 64'(m_tvalid), 64'd0);
    checkOutput("reset_tdata", 64'(m_tdata), 64'd0);
    checkOutput("reset_fill", 64'(fill), 64'd0);
    checkOutput("reset_cnts", 64'({frame_cnt, short_err_cnt, long_err_cnt, ovf_cnt}), 64'd0);
    tx_rstn = 1'b1;

    // Single frame after an idle run; word appears right after the bit-0 edge.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
    sendFrame(48'hA5A5_1234_5678, 1'b1);
    checkOutput("t1_valid", 64'(m_tvalid), 64'd1);
    checkOutput("t1_tdata", 64'(m_tdata), 64'hA5A5_1234_5678);
    checkOutput("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    waitDrain();
    checkOutput("t1_fill", 64'(fill), 64'd0);

    // Back-to-back frames sharing a single delimiter cycle.
    clearStats();
    sendFrame(48'h0, 1'b1);
    sendFrame(48'hFFFF_FFFF_FFFF, 1'b1);
    sendFrame(48'h8000_0000_0001, 1'b1);
    waitDrain();
    checkOutput("t2_frame_cnt", 64'(frame_cnt), 64'd3);
    checkOutput("t2_err_cnts", 64'({short_err_cnt, long_err_cnt, ovf_cnt}), 64'd0);

    // Short frame, then a good one.
    clearStats();
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'(i));
    applyStimulus(1'b1, 1'b1);
    checkOutput("t3_short", 64'(short_err_cnt), 64'd1);
    checkOutput("t3_no_push", 64'(fill), 64'd0);
    sendFrame(48'h1357_9BDF_2468, 1'b1);
    waitDrain();
    checkOutput("t3_frame_cnt", 64'(frame_cnt), 64'd1);

    // Over-long run: error on the 48th low cycle, then hunting.
    clearStats();
    for (int i = 0; i < 47; i++) applyStimulus(1'b0, 1'(i));
    checkOutput("t4_long_before", 64'(long_err_cnt), 64'd0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t4_long_at48", 64'(long_err_cnt), 64'd1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'(i));
    checkOutput("t4_quiet", 64'({frame_cnt, short_err_cnt, 13'd0, fill}), 64'd0);
    applyStimulus(1'b1, 1'b0);
    sendFrame(48'hCAFE_F00D_BEEF, 1'b1);
    waitDrain();
    checkOutput("t4_frame_cnt", 64'(frame_cnt), 64'd1);
    checkOutput("t4_long_final", 64'(long_err_cnt), 64'd1);

    // Overflow with downstream stalled, then drain in order.
    clearStats();
    m_tready = 1'b0;
    for (int k = 0; k < 6; k++) sendFrame(t5w[k], k < 4);
    checkOutput("t5_fill_full", 64'(fill), 64'd4);
    checkOutput("t5_ovf", 64'(ovf_cnt), 64'd2);
    checkOutput("t5_frame_cnt", 64'(frame_cnt), 64'd4);
    checkOutput("t5_head_stable", 64'(m_tdata), 64'(t5w[0]));
    m_tready = 1'b1;
    waitDrain();
    checkOutput("t5_fill_empty", 64'(fill), 64'd0);

    // Push into a full FIFO accepted thanks to a same-cycle pop.
    clearStats();
    m_tready = 1'b0;
    for (int k = 0; k < 4; k++) sendFrame(t5w[k], 1'b1);
    w = t5w[4];
    for (int i = 47; i >= 1; i--) applyStimulus(1'b0, w[i]);
    m_tready = 1'b1;
    expQ.push_back(w);
    applyStimulus(1'b1, w[0]);
    checkOutput("t5b_fill", 64'(fill), 64'd4);
    checkOutput("t5b_ovf", 64'(ovf_cnt), 64'd0);
    checkOutput("t5b_frame_cnt", 64'(frame_cnt), 64'd5);
    waitDrain();

    // Enable dropped mid-frame: the rest of that frame is ignored.
    clearStats();
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1);
    enable = 1'b0;
    applyStimulus(1'b0, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 27; i++) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("en_no_push", 64'(fill), 64'd0);
    checkOutput("en_cnts", 64'({frame_cnt, short_err_cnt, long_err_cnt}), 64'd0);
    sendFrame(48'h0F0F_0F0F_0F0F, 1'b1);
    waitDrain();
    checkOutput("en_frame_cnt", 64'(frame_cnt), 64'd1);

    // Statistics clear beats a same-cycle frame count.
    clearStats();
    w = 48'h5555_AAAA_5555;
    for (int i = 47; i >= 1; i--) applyStimulus(1'b0, w[i]);
    stat_clear = 1'b1;
    expQ.push_back(w);
    applyStimulus(1'b1, w[0]);
    stat_clear = 1'b0;
    checkOutput("clr_wins", 64'(frame_cnt), 64'd0);
    waitDrain();

    // Reset in the middle of a frame with a word still buffered.
    m_tready = 1'b0;
    sendFrame(48'h9999_8888_7777, 1'b1);
    w = 48'h3C3C_3C3C_3C3C;
    for (int i = 47; i >= 18; i--) applyStimulus(1'b0, w[i]);
    tx_rstn = 1'b0;
    expQ.delete();
    #1;
    checkOutput("rst_valid", 64'(m_tvalid), 64'd0);
    checkOutput("rst_tdata", 64'(m_tdata), 64'd0);
    checkOutput("rst_fill", 64'(fill), 64'd0);
    checkOutput("rst_cnts", 64'({frame_cnt, short_err_cnt, long_err_cnt, ovf_cnt}), 64'd0);
    applyStimulus(1'b1, 1'b0);
    tx_rstn = 1'b1;
    m_tready = 1'b1;
    applyStimulus(1'b1, 1'b0);
    sendFrame(48'hFEDC_BA98_7654, 1'b1);
    waitDrain();
    checkOutput("rst_frame_cnt", 64'(frame_cnt), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
